// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the bus sequencer: state encoding, opcode map and
// instruction-register field positions.
package bus_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        ILL
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_AND  = 5'h05;
    localparam logic [4:0] OP_OR   = 5'h06;
    localparam logic [4:0] OP_SHR  = 5'h07;
    localparam logic [4:0] OP_SHRA = 5'h08;
    localparam logic [4:0] OP_SHL  = 5'h09;
    localparam logic [4:0] OP_ROR  = 5'h0A;
    localparam logic [4:0] OP_NEG  = 5'h0B;
    localparam logic [4:0] OP_NOT  = 5'h0C;
    localparam logic [4:0] OP_XOR  = 5'h0D;
    localparam logic [4:0] OP_ROL  = 5'h0E;
    localparam logic [4:0] OP_MUL  = 5'h0F;
    localparam logic [4:0] OP_DIV  = 5'h10;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RA_MSB     = 26;
    localparam int RA_LSB     = 23;
    localparam int RB_MSB     = 22;
    localparam int RB_LSB     = 19;
    localparam int RC_MSB     = 18;
    localparam int RC_LSB     = 15;

    // Any opcode from ADD through DIV is executable; everything else traps.
    function automatic logic is_legal(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_DIV);
    endfunction

    // MUL and DIV produce a 64-bit result that needs the extra HI write-back.
    function automatic logic is_mul_div(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/bus_sequencer_dec4to16.sv
// 4-to-16 one-hot decoder used to turn a register number into a select line.
module dec4to16 (
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);

    // Exactly one output bit is set, the one matching the register number.
    always_comb begin
        onehot = 16'(1) << sel;
    end

endmodule

// File: rtl/bus_sequencer.sv
// Control sequencer for a single-bus datapath: fetches an instruction and
// steps it through the register/ALU transfers with registered control lines.
module bus_sequencer
    import bus_sequencer_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic           clock,
    input  logic           clear,
    input  logic           run,
    input  logic [31:0]    ir,
    output logic           PC_out,
    output logic           MDR_out,
    output logic           Z_high_out,
    output logic           Z_low_out,
    output logic           HI_out,
    output logic           LO_out,
    output logic [15:0]    R_out,
    output logic           PC_in,
    output logic           MAR_in,
    output logic           MDR_in,
    output logic           IR_in,
    output logic           Y_in,
    output logic           Z_in,
    output logic           HI_in,
    output logic           LO_in,
    output logic [15:0]    R_in,
    output logic           Read,
    output logic           IncPC,
    output logic [OPW-1:0] alu_op,
    output logic           busy,
    output logic           done,
    output logic           err
);

    state_t      state;
    state_t      next_state;
    logic [4:0]  opcode_q;
    logic [3:0]  ra_q;
    logic [3:0]  rc_q;
    logic [3:0]  rd_sel;
    logic [15:0] rd_onehot;
    logic [15:0] wr_onehot;
    logic        unused_ir_bits;

    assign unused_ir_bits = ^ir[RC_LSB-1:0];

    // Source register for the upcoming bus read: rb straight from ir when
    // entering T3 (its effect is captured in R_out), latched rc afterwards.
    always_comb begin
        rd_sel = (state == T2) ? ir[RB_MSB:RB_LSB] : rc_q;
    end

    dec4to16 u_rd_dec (
        .sel    (rd_sel),
        .onehot (rd_onehot)
    );

    dec4to16 u_wr_dec (
        .sel    (ra_q),
        .onehot (wr_onehot)
    );

    // Next-state selection; run is only looked at in IDLE and the final state.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = run ? T0 : IDLE;
            T0:      next_state = T1;
            T1:      next_state = T2;
            T2:      next_state = T3;
            T3:      next_state = is_legal(opcode_q) ? T4 : ILL;
            T4:      next_state = T5;
            T5:      next_state = is_mul_div(opcode_q) ? T6 : (run ? T0 : IDLE);
            T6:      next_state = run ? T0 : IDLE;
            ILL:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register with outputs registered for the state being entered.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state      <= IDLE;
            opcode_q   <= '0;
            ra_q       <= '0;
            rc_q       <= '0;
            PC_out     <= 1'b0;
            MDR_out    <= 1'b0;
            Z_high_out <= 1'b0;
            Z_low_out  <= 1'b0;
            HI_out     <= 1'b0;
            LO_out     <= 1'b0;
            R_out      <= '0;
            PC_in      <= 1'b0;
            MAR_in     <= 1'b0;
            MDR_in     <= 1'b0;
            IR_in      <= 1'b0;
            Y_in       <= 1'b0;
            Z_in       <= 1'b0;
            HI_in      <= 1'b0;
            LO_in      <= 1'b0;
            R_in       <= '0;
            Read       <= 1'b0;
            IncPC      <= 1'b0;
            alu_op     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= next_state;
            PC_out     <= 1'b0;
            MDR_out    <= 1'b0;
            Z_high_out <= 1'b0;
            Z_low_out  <= 1'b0;
            HI_out     <= 1'b0;
            LO_out     <= 1'b0;
            R_out      <= '0;
            PC_in      <= 1'b0;
            MAR_in     <= 1'b0;
            MDR_in     <= 1'b0;
            IR_in      <= 1'b0;
            Y_in       <= 1'b0;
            Z_in       <= 1'b0;
            HI_in      <= 1'b0;
            LO_in      <= 1'b0;
            R_in       <= '0;
            Read       <= 1'b0;
            IncPC      <= 1'b0;
            alu_op     <= '0;
            busy       <= (next_state != IDLE);
            done       <= 1'b0;
            err        <= 1'b0;
            case (next_state)
                T0: begin
                    PC_out <= 1'b1;
                    MAR_in <= 1'b1;
                    IncPC  <= 1'b1;
                    Z_in   <= 1'b1;
                end
                T1: begin
                    Z_low_out <= 1'b1;
                    PC_in     <= 1'b1;
                    Read      <= 1'b1;
                    MDR_in    <= 1'b1;
                end
                T2: begin
                    MDR_out <= 1'b1;
                    IR_in   <= 1'b1;
                end
                T3: begin
                    opcode_q <= ir[OPCODE_MSB:OPCODE_LSB];
                    ra_q     <= ir[RA_MSB:RA_LSB];
                    rc_q     <= ir[RC_MSB:RC_LSB];
                    R_out    <= rd_onehot;
                    Y_in     <= 1'b1;
                end
                T4: begin
                    R_out  <= rd_onehot;
                    Z_in   <= 1'b1;
                    alu_op <= OPW'(opcode_q);
                end
                T5: begin
                    Z_low_out <= 1'b1;
                    if (is_mul_div(opcode_q)) begin
                        LO_in <= 1'b1;
                    end else begin
                        R_in <= wr_onehot;
                        done <= 1'b1;
                    end
                end
                T6: begin
                    Z_high_out <= 1'b1;
                    HI_in      <= 1'b1;
                    done       <= 1'b1;
                end
                ILL: begin
                    err <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 Parameter: OPW, default 5, opcode field width.
REQ-002 Port: clock  in  1  rising-edge system clock.
REQ-003 Port: clear  in  1  synchronous, active-low reset.
REQ-004 Port: run  in  1  start/continue request, level-sampled.
REQ-005 Port: ir  in  32  instruction register; opcode=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
REQ-006 Ports: PC_out, MDR_out, Z_high_out, Z_low_out, HI_out, LO_out  out  1 each  bus-drive selects.
REQ-007 Port: R_out  out  16  one-hot register-drive selects; bit n drives Rn.
REQ-008 Ports: PC_in, MAR_in, MDR_in, IR_in, Y_in, Z_in, HI_in, LO_in  out  1 each  load enables.
REQ-009 Port: R_in  out  16  one-hot register load enables.
REQ-010 Ports: Read, IncPC  out  1 each  memory-read strobe, ALU PC-increment mode.
REQ-011 Port: alu_op  out  OPW  ALU operation code, 0 when not in T4.
REQ-012 Ports: busy, done, err  out  1 each  sequencing active, instruction completed (1-cycle pulse), illegal opcode (1-cycle pulse).

Function
REQ-013 The FSM SHALL have states IDLE, T0, T1, T2, T3, T4, T5, T6, ILL.
REQ-014 IDLE: all control outputs SHALL be 0; run=1 -> T0 on the next edge.
REQ-015 T0: PC_out, MAR_in, IncPC, Z_in SHALL be 1; -> T1.
REQ-016 T1: Z_low_out, PC_in, Read, MDR_in SHALL be 1; -> T2.
REQ-017 T2: MDR_out, IR_in SHALL be 1; -> T3.
REQ-018 T3: latch opcode/ra/rb/rc from ir; R_out[rb], Y_in SHALL be 1; illegal opcode -> ILL, else -> T4.
REQ-019 T4: R_out[rc], Z_in SHALL be 1; alu_op SHALL equal latched opcode; -> T5.
REQ-020 T5 single-result op: Z_low_out, R_in[ra], done SHALL be 1; -> T0 if run=1, else IDLE.
REQ-021 T5 MUL/DIV: Z_low_out, LO_in SHALL be 1; -> T6.
REQ-022 T6: Z_high_out, HI_in, done SHALL be 1; -> T0 if run=1, else IDLE.
REQ-023 ILL: err SHALL be 1, no bus driver asserted; -> IDLE regardless of run.
REQ-024 Legal opcodes: ADD..ROL (0x03-0x0E) single-result; MUL 0x0F, DIV 0x10; all others illegal.
REQ-025 At most one bus-drive select (REQ-006/007 combined) SHALL be 1 in any cycle.
REQ-026 At most one R_in bit SHALL be 1 in any cycle; ra=0 is a legal destination.
REQ-027 busy SHALL be 1 in T0-T6 and ILL, 0 in IDLE.
REQ-028 Latency: ALU op 6 cycles T0-T5, MUL/DIV 7 cycles T0-T6; back-to-back run gives zero idle cycles.
REQ-029 run changes during T0-T6 SHALL have no effect until the final state.
REQ-030 Fields latched in T3 SHALL stay stable through T6 independent of later ir changes.

Reset
REQ-031 clear=0 at a rising edge SHALL force IDLE and zero all outputs and latched fields, from any state.
REQ-032 clear SHALL dominate run; deasserting clear with run=1 enters T0 one edge later.

Structure
REQ-033 A shared package SHALL hold the state enum, opcode constants (ADD..DIV), and IR field bit positions.
REQ-034 Sub-module dec4to16 SHALL implement the 4-to-16 one-hot decode used for R_out and R_in.

Verification
REQ-035 Reset run=1, ir=0x18918000 (add r1,r2,r3) -> T0..T5 visited; T3 R_out=0x0004; T4 R_out=0x0008, alu_op=0x03; T5 R_in=0x0002, done=1; then T0.
REQ-036 ir=0x78228000 (mul rb=4, rc=5), run dropped after T0 -> T5 LO_in=1; T6 Z_high_out=1, HI_in=1, done=1; IDLE next.
REQ-037 ir opcode 0x1F -> T3 then ILL with err=1 for 1 cycle; IDLE; no R_in bit ever set.
REQ-038 clear=0 during T4 -> next cycle IDLE, all outputs 0, busy=0.
REQ-039 Random ir and run for 10k cycles -> checker confirms REQ-025/026 every cycle and done count equals legal instructions completed.
REQ-040 ir changed to 0x00000000 during T4 of add r1,r2,r3 -> T5 still asserts R_in=0x0002.
